// File: rtl/multi_axis_sim_if.sv
// Bus bundle for multi_axis_sim: channel force/gravity/calibration inputs and position/status outputs.
// update_valid and tick are one-cycle strobes with no ready/backpressure; consumers must sample them the cycle they are high.
interface multi_axis_sim_if #(
  parameter int NUM_CH    = 2,
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16
);
  localparam int W = INT_BITS + FRAC_BITS;

  logic                       enable;
  logic [NUM_CH*W-1:0]        ch_force;
  logic [W-1:0]               gravity;
  logic [NUM_CH-1:0]          calib_start;
  logic [NUM_CH-1:0]          calib_done;
  logic [NUM_CH*INT_BITS-1:0] current_pos;
  logic [NUM_CH*INT_BITS-1:0] delta_steps;
  logic                       tick;
  logic                       update_valid;
  logic                       busy;
  logic                       overrun;
  logic [2:0]                 dbg_state;

  modport master (
    output enable, ch_force, gravity, calib_start, calib_done,
    input  current_pos, delta_steps, tick, update_valid, busy, overrun, dbg_state
  );

  modport slave (
    input  enable, ch_force, gravity, calib_start, calib_done,
    output current_pos, delta_steps, tick, update_valid, busy, overrun, dbg_state
  );
endinterface

// File: rtl/multi_axis_sim.sv
// N-channel fixed-point 1-D integrator: one shared datapath sequenced over channels once per tick.
// Define SIM_DAMPING_EN to add speed damping (speed -= speed >>> DAMP_SHIFT) in the INTEG step.
module multi_axis_sim #(
  parameter int          NUM_CH     = 2,
  parameter int          SIM_PERIOD = 500_000,
  parameter int          INT_BITS   = 16,
  parameter int          FRAC_BITS  = 16,
  parameter int          MAX_POS    = 3200,
  parameter logic [31:0] MAX_SPEED  = 32'h0010_0000
`ifdef SIM_DAMPING_EN
  ,
  parameter int          DAMP_SHIFT = 6
`endif
) (
  input logic             clock,
  input logic             reset,
  multi_axis_sim_if.slave bus
);
  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int CW = $clog2(SIM_PERIOD);
  localparam int HW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam longint IMAX_L = (longint'(1) <<< (W - 1)) - 1;
  localparam logic signed [W+1:0] SMAX = (W+2)'(MAX_SPEED);
  localparam logic signed [W+1:0] SMIN = -SMAX;
  localparam logic signed [W+1:0] PMAX = (W+2)'(longint'(MAX_POS) <<< FRAC_BITS);
  localparam logic signed [W+1:0] IMAX = (W+2)'(IMAX_L);
  localparam logic signed [W+1:0] IMIN = (W+2)'(-IMAX_L - 1);
  localparam logic signed [INT_BITS-1:0] WALL_HI = INT_BITS'(MAX_POS);

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD, S_ACC, S_INTEG, S_WRITE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [HW-1:0] ch;
  logic          wrap, last_ch, seq_done;
  logic          tick_q, update_q, overrun_q;

  logic signed [W-1:0]  speed   [NUM_CH];
  logic signed [W-1:0]  pos     [NUM_CH];
  logic [INT_BITS-1:0]  cur_pos [NUM_CH];
  logic [INT_BITS-1:0]  dlt     [NUM_CH];
  logic [NUM_CH-1:0]    cal_active;

  logic                 skip;
  logic signed [W:0]    a_reg;
  logic signed [W-1:0]  v_reg, s_reg, p_reg;

  logic signed [W-1:0]        f_ch, v_d, s_sat, s_new, p_new;
  logic signed [W:0]          a_sum;
  logic signed [INT_BITS-1:0] pos_int;
  logic                       wall;
  logic signed [W+1:0]        s_full, p_full;
  logic [INT_BITS-1:0]        new_int;

  assign wrap     = bus.enable && (cnt == CW'(SIM_PERIOD - 1));
  assign last_ch  = (ch == HW'(NUM_CH - 1));
  // A tick landing on the final WRITE restarts the sequence back-to-back instead of counting as overrun.
  assign seq_done = (state == S_IDLE) || (state == S_WRITE && last_ch);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_LOAD:  state_nxt = S_ACC;
      S_ACC:   state_nxt = S_INTEG;
      S_INTEG: state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_ch ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
    if (wrap && seq_done) state_nxt = S_LOAD;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch        <= '0;
      tick_q    <= 1'b0;
      update_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_q   <= wrap;
      update_q <= (state == S_WRITE) && last_ch;
      if (bus.enable) cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap && !seq_done) overrun_q <= 1'b1;
      if (wrap && seq_done) ch <= '0;
      else if (state == S_WRITE && !last_ch) ch <= ch + HW'(1);
    end
  end

  always_comb begin
    f_ch    = bus.ch_force[int'(ch)*W +: W];
    a_sum   = {f_ch[W-1], f_ch} + {bus.gravity[W-1], bus.gravity};
    pos_int = pos[ch][W-1:FRAC_BITS];
    wall    = 1'b0;
    if (!cal_active[ch])
      wall = ((pos_int[INT_BITS-1] || pos_int == '0) && a_sum[W]) ||
             (pos_int >= WALL_HI && !a_sum[W] && a_sum != '0);
`ifdef SIM_DAMPING_EN
    v_d = v_reg - (v_reg >>> DAMP_SHIFT);
`else
    v_d = v_reg;
`endif
    s_full = {{2{v_d[W-1]}}, v_d} + {a_reg[W], a_reg};
    if (s_full > SMAX)      s_sat = SMAX[W-1:0];
    else if (s_full < SMIN) s_sat = SMIN[W-1:0];
    else                    s_sat = s_full[W-1:0];
    p_full = {{2{pos[ch][W-1]}}, pos[ch]} + {{2{s_sat[W-1]}}, s_sat};
    s_new  = s_sat;
    p_new  = p_full[W-1:0];
    // Walls stop the channel dead; calibration only guards against integer wrap.
    if (!cal_active[ch]) begin
      if (p_full[W+1]) begin
        p_new = '0;
        s_new = '0;
      end else if (p_full > PMAX) begin
        p_new = PMAX[W-1:0];
        s_new = '0;
      end
    end else begin
      if (p_full > IMAX)      p_new = IMAX[W-1:0];
      else if (p_full < IMIN) p_new = IMIN[W-1:0];
    end
    new_int = p_reg[W-1:FRAC_BITS];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        speed[i]   <= '0;
        pos[i]     <= '0;
        cur_pos[i] <= '0;
        dlt[i]     <= '0;
      end
      cal_active <= '0;
      skip       <= 1'b0;
      a_reg      <= '0;
      v_reg      <= '0;
      s_reg      <= '0;
      p_reg      <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          skip <= 1'b0;
          if (bus.calib_start[ch]) begin
            cal_active[ch] <= 1'b1;
            skip           <= 1'b1;
          end else if (bus.calib_done[ch]) begin
            cal_active[ch] <= 1'b0;
            speed[ch]      <= '0;
            pos[ch]        <= '0;
            cur_pos[ch]    <= '0;
            dlt[ch]        <= '0;
            skip           <= 1'b1;
          end
        end
        S_ACC: begin
          a_reg <= wall ? '0 : a_sum;
          v_reg <= wall ? '0 : speed[ch];
        end
        S_INTEG: begin
          s_reg <= s_new;
          p_reg <= p_new;
        end
        S_WRITE: begin
          if (!skip) begin
            dlt[ch]     <= new_int - cur_pos[ch];
            cur_pos[ch] <= new_int;
            speed[ch]   <= s_reg;
            pos[ch]     <= p_reg;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_out
    assign bus.current_pos[i*INT_BITS +: INT_BITS] = cur_pos[i];
    assign bus.delta_steps[i*INT_BITS +: INT_BITS] = dlt[i];
  end

  assign bus.tick         = tick_q;
  assign bus.update_valid = update_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.overrun      = overrun_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_multi_axis_sim.sv
// Directed bench for multi_axis_sim: wall clamping, speed saturation, calibration and overrun.
module tb_multi_axis_sim;
  localparam logic [31:0] F_ONE   = 32'h0001_0000;
  localparam logic [31:0] F_MONE  = 32'hFFFF_0000;
  localparam logic [31:0] F_MHALF = 32'hFFFF_8000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  multi_axis_sim_if bus ();
  multi_axis_sim_if fast_bus ();

  multi_axis_sim #(
    .NUM_CH(2), .SIM_PERIOD(16), .INT_BITS(16), .FRAC_BITS(16),
    .MAX_POS(8), .MAX_SPEED(32'h0002_0000)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  multi_axis_sim #(
    .NUM_CH(2), .SIM_PERIOD(6), .INT_BITS(16), .FRAC_BITS(16),
    .MAX_POS(8), .MAX_SPEED(32'h0002_0000)
  ) dut_fast (
    .clock(clock), .reset(reset), .bus(fast_bus)
  );

`ifdef SIM_DAMPING_EN
  multi_axis_sim_if damp_bus ();
  multi_axis_sim #(
    .NUM_CH(2), .SIM_PERIOD(16), .INT_BITS(16), .FRAC_BITS(16),
    .MAX_POS(8), .MAX_SPEED(32'h0002_0000), .DAMP_SHIFT(1)
  ) dut_damp (
    .clock(clock), .reset(reset), .bus(damp_bus)
  );
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ch(input string tag, input int c, input int exp_pos, input int exp_del);
    logic [15:0] e_p, e_d, o_p, o_d;
    e_p = 16'(exp_pos);
    e_d = 16'(exp_del);
    o_p = bus.current_pos[c*16 +: 16];
    o_d = bus.delta_steps[c*16 +: 16];
    chk($sformatf("%s_pos_ch%0d", tag, c), {16'h0, o_p}, {16'h0, e_p});
    chk($sformatf("%s_delta_ch%0d", tag, c), {16'h0, o_d}, {16'h0, e_d});
  endtask

  task automatic set_force(input int c, input logic [31:0] v);
    bus.ch_force[c*32 +: 32] = v;
  endtask

  // Waits for the next tick, then for update_valid; lat = cycles from tick to update_valid.
  task automatic wait_update(output int lat);
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("tick_seen", {31'h0, bus.tick}, 32'd1);
    n = 0;
    while (bus.update_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("update_seen", {31'h0, bus.update_valid}, 32'd1);
    lat = n;
  endtask

  initial begin
    int lat;
    int n;
    int p2[4];
    int d2[4];
    int p4[5];
    int d4[5];
    int p5[3];
    int d5[3];
    p2 = '{1, 3, 5, 7};
    d2 = '{1, 2, 2, 2};
    p4 = '{8, 8, 7, 5, 3};
    d4 = '{1, 0, -1, -2, -2};
    p5 = '{-1, -3, -5};
    d5 = '{-1, -2, -2};

    bus.enable = 1'b0;
    bus.ch_force = '0;
    bus.gravity = '0;
    bus.calib_start = '0;
    bus.calib_done = '0;
    fast_bus.enable = 1'b1;
    fast_bus.ch_force = '0;
    fast_bus.gravity = '0;
    fast_bus.calib_start = '0;
    fast_bus.calib_done = '0;
`ifdef SIM_DAMPING_EN
    damp_bus.enable = 1'b1;
    damp_bus.ch_force = '0;
    damp_bus.gravity = '0;
    damp_bus.calib_start = '0;
    damp_bus.calib_done = '0;
`endif
    repeat (3) @(negedge clock);

    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_state", {29'h0, bus.dbg_state}, 32'd0);
    chk("rst_pos", bus.current_pos, 32'd0);
    chk("rst_delta", bus.delta_steps, 32'd0);
    chk("rst_tick", {31'h0, bus.tick}, 32'd0);
    chk("rst_update", {31'h0, bus.update_valid}, 32'd0);
    chk("rst_overrun", {31'h0, bus.overrun}, 32'd0);

    reset = 1'b0;
    bus.enable = 1'b1;

    // Reset in the middle of a sequence.
    n = 0;
    while (bus.busy !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("busy_seen", {31'h0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", {31'h0, bus.busy}, 32'd0);
    chk("midrst_state", {29'h0, bus.dbg_state}, 32'd0);
    chk("midrst_overrun", {31'h0, bus.overrun}, 32'd0);
    chk("midrst_tick", {31'h0, bus.tick}, 32'd0);
    chk("midrst_pos", bus.current_pos, 32'd0);
    reset = 1'b0;

    // Lower wall holds a channel pushed downward at 0.
    set_force(0, F_MHALF);
    for (int i = 0; i < 2; i++) begin
      wait_update(lat);
      chk_ch("lowwall", 0, 0, 0);
    end

    // Constant +1.0 force; speed saturates at 2.0 per tick.
    set_force(0, F_ONE);
    for (int i = 0; i < 4; i++) begin
      wait_update(lat);
      chk("latency", 32'(lat), 32'd8);
      chk_ch("accel", 0, p2[i], d2[i]);
      chk_ch("idle", 1, 0, 0);
      @(negedge clock);
      chk("update_pulse", {31'h0, bus.update_valid}, 32'd0);
    end

    // Upper wall, then reverse.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_force(0, F_MONE);
      wait_update(lat);
      chk_ch("upwall", 0, p4[i], d4[i]);
    end

    // Calibration lets channel 1 go negative; calib_done zeroes it.
    set_force(0, '0);
    set_force(1, F_MONE);
    bus.calib_start = 2'b10;
    wait_update(lat);
    chk_ch("cal_entry", 1, 0, 0);
    bus.calib_start = 2'b00;
    for (int i = 0; i < 3; i++) begin
      wait_update(lat);
      chk_ch("cal_move", 1, p5[i], d5[i]);
    end
    bus.calib_done = 2'b10;
    wait_update(lat);
    chk_ch("cal_done", 1, 0, 0);
    bus.calib_done = 2'b00;
    wait_update(lat);
    chk_ch("cal_wall", 1, 0, 0);
    chk("main_overrun", {31'h0, bus.overrun}, 32'd0);

    // Tick period too short for the sequence.
    chk("fast_overrun", {31'h0, fast_bus.overrun}, 32'd1);
    repeat (20) @(negedge clock);
    chk("fast_overrun_sticky", {31'h0, fast_bus.overrun}, 32'd1);

`ifdef SIM_DAMPING_EN
    n = 0;
    while (damp_bus.update_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    damp_bus.ch_force[31:0] = F_ONE;
    p5 = '{1, 2, 4};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n = 0;
      while (damp_bus.update_valid !== 1'b1 && n < 40) begin
        @(negedge clock);
        n++;
      end
      chk("damp_update", {31'h0, damp_bus.update_valid}, 32'd1);
      chk("damp_pos", {16'h0, damp_bus.current_pos[15:0]}, {16'h0, 16'(p5[i])});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
